ecc_insn_sequencer: RTL

//  Instruction issue side of the ECC datapath: fetches 20-bit instructions from instruction memory,

---
 rtl/ecc_insn_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ecc_insn_sequencer.sv
// rtl/ecc_insn_sequencer.sv - instruction fetch/issue sequencer for the ECC datapath
// Owns PC, NZP flags, carry, branch/JSR resolution, writeback strobe and halt/watchdog stop.
module ecc_insn_sequencer #(
  parameter int WORD_SIZE = 256,
  parameter int INSN      = 19,
  parameter int IADDR     = 10,
  parameter int MAX_INSNS = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [IADDR:0]       i_start_pc,
  output logic                 o_imem_req,
  output logic [IADDR:0]       o_imem_addr,
  input  logic                 i_imem_valid,
  input  logic [INSN:0]        i_imem_insn,
  output logic [INSN:0]        o_insn,
  output logic [IADDR:0]       o_pc,
  output logic                 o_carry,
  input  logic [WORD_SIZE-1:0] i_alu_result,
  output logic                 o_wb_en,
  output logic [WORD_SIZE-1:0] o_wb_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [15:0]          o_insn_count
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WB, S_DONE} state_t;

  localparam logic [15:0] MAX_CNT = MAX_INSNS[15:0];

  state_t     state;
  logic [2:0] nzp;
  logic [4:0] opcode;
  logic [2:0] br_mask;
  logic       is_nop, is_jsr, is_alu, is_chk, is_halt, is_illegal, br_taken;
  logic [15:0] count_next;
  logic        wd_hit, res_n, res_z;
  logic [IADDR:0] pc_inc, pc_target;

  assign opcode      = o_insn[INSN -: 5];
  assign o_imem_addr = o_pc;

  always_comb begin
    is_nop  = 1'b0;
    is_jsr  = 1'b0;
    is_alu  = 1'b0;
    is_chk  = 1'b0;
    is_halt = 1'b0;
    br_mask = 3'b000;
    case (opcode)
      5'b00000: is_nop = 1'b1;
      5'b00001: br_mask = 3'b010;
      5'b00010: br_mask = 3'b011;
      5'b00011: br_mask = 3'b101;
      5'b00100: br_mask = 3'b110;
      5'b01000: is_jsr = 1'b1;
      5'b00101, 5'b00110, 5'b00111, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
      5'b01101, 5'b01110, 5'b01111, 5'b10010, 5'b10100, 5'b10101: is_alu = 1'b1;
      5'b10000, 5'b10011: begin
        is_alu = 1'b1;
        is_chk = 1'b1;
      end
      5'b11111: is_halt = 1'b1;
      default: ;
    endcase
  end

  // Branches test the flags left by earlier ALU ops, never the branch's own result.
  assign br_taken   = |(br_mask & nzp);
  assign is_illegal = ~(is_nop | is_jsr | is_alu | is_halt | (|br_mask));
  assign count_next = (o_insn_count == MAX_CNT) ? o_insn_count : o_insn_count + 16'd1;
  assign wd_hit     = (count_next == MAX_CNT);
  assign res_n      = o_wb_data[WORD_SIZE-1];
  assign res_z      = ~|o_wb_data;
  assign pc_inc     = o_pc + {{IADDR{1'b0}}, 1'b1};
  assign pc_target  = o_wb_data[IADDR:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      nzp          <= 3'b010;
      o_imem_req   <= 1'b0;
      o_insn       <= '0;
      o_pc         <= '0;
      o_carry      <= 1'b0;
      o_wb_en      <= 1'b0;
      o_wb_data    <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_insn_count <= '0;
    end else begin
      o_wb_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state        <= S_FETCH;
            o_pc         <= i_start_pc;
            o_insn_count <= '0;
            o_error      <= 1'b0;
            nzp          <= 3'b010;
            o_carry      <= 1'b0;
            o_done       <= 1'b0;
            o_busy       <= 1'b1;
            o_imem_req   <= 1'b1;
          end
        end
        S_FETCH: begin
          if (i_imem_valid) begin
            o_insn     <= i_imem_insn;
            o_imem_req <= 1'b0;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          o_wb_data <= i_alu_result;
          o_wb_en   <= is_alu;
          state     <= S_WB;
        end
        S_WB: begin
          o_insn_count <= count_next;
          if (is_alu) begin
            nzp <= {res_n, res_z, ~res_n & ~res_z};
          end
          if (is_chk) begin
            o_carry <= o_wb_data[0];
          end
          o_pc <= (is_jsr || br_taken) ? pc_target : pc_inc;
          if (is_halt || is_illegal || wd_hit) begin
            state   <= S_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_error <= is_illegal | wd_hit;
          end else begin
            state      <= S_FETCH;
            o_imem_req <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
